cdb_scheduler: RTL and testbench

- Round-robin scheduler that shares the single Common Data Bus between NUM_UF functional units.
- Each unit hands over one finished result (Done + Q). The block buffers it in a per-unit holding slot, grants exactly one slot per cycle, and drives the registered CDB broadcast (Write_Enable_CDB, Qi_CDB, Qi_CDB_data).
- Consumers are the register status table and the reservation stations.
- Per-unit back-pressure through Accept.

---
 rtl/tomasulo_pkg.sv | 13 +
 rtl/rr_picker.sv | 35 +++
 rtl/cdb_scheduler.sv | 136 +++++++++++++
 tb/tb_cdb_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: constants shared by the Tomasulo datapath blocks.
//   DATA_W / TAG_W     default result and CDB tag widths
//   FREE_REGISTER      tag value meaning "no producer"; never broadcast
//   RES_STATION_ADD1/2 reservation-station ids of the two adder stations
//   sem_valor          idle value driven on the CDB data lines
package tomasulo_pkg;
  localparam int          DATA_W           = 16;
  localparam int          TAG_W            = 4;
  localparam int          FREE_REGISTER    = 0;
  localparam int          RES_STATION_ADD1 = 1;
  localparam int          RES_STATION_ADD2 = 2;
  localparam logic [15:0] sem_valor        = 16'hFFF0;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   i_req       request vector, one bit per requester
//   i_ptr       index that has highest priority this cycle (< NUM_UF)
//   o_win       first requesting index at or after i_ptr, wrapping
//   o_win_valid at least one request is set
module rr_picker #(
  parameter int NUM_UF = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_UF-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [PTR_W-1:0]  o_win,
  output logic              o_win_valid
);

  logic [PTR_W:0] w_idx;

  // Scan from the farthest offset down to offset 0 so the closest
  // requester to the pointer is the last (and therefore final) assignment.
  always_comb begin
    o_win       = '0;
    o_win_valid = 1'b0;
    w_idx       = '0;
    for (int k = NUM_UF - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_idx >= (PTR_W + 1)'(NUM_UF))
        w_idx = w_idx - (PTR_W + 1)'(NUM_UF);
      if (i_req[w_idx[PTR_W-1:0]]) begin
        o_win       = w_idx[PTR_W-1:0];
        o_win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: shares the Common Data Bus between NUM_UF functional units.
// Each unit hands one result into its holding slot (Done/Accept handshake);
// one held slot per cycle is granted round-robin and broadcast on the
// registered CDB outputs.
//   Clock, Reset        clock, async active-low reset
//   Flush               synchronous clear of slots, pointer and CDB outputs
//   Done, Q_bus         per-unit result valid and data (unit i at i*DATA_W)
//   Accept              per-unit ready (combinational)
//   Write_Enable_CDB    broadcast valid
//   Qi_CDB, Qi_CDB_data broadcast tag (TAG_BASE+unit) and value
//   Grant_onehot        source unit of the current broadcast
//   Pending             number of occupied slots
module cdb_scheduler #(
  parameter int NUM_UF   = 4,
  parameter int DATA_W   = tomasulo_pkg::DATA_W,
  parameter int TAG_W    = tomasulo_pkg::TAG_W,
  parameter int TAG_BASE = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic [NUM_UF-1:0]        Done,
  input  logic [NUM_UF*DATA_W-1:0] Q_bus,
  output logic [NUM_UF-1:0]        Accept,
  output logic                     Write_Enable_CDB,
  output logic [TAG_W-1:0]         Qi_CDB,
  output logic [DATA_W-1:0]        Qi_CDB_data,
  output logic [NUM_UF-1:0]        Grant_onehot,
  output logic [3:0]               Pending
);
  import tomasulo_pkg::*;

  localparam int PTR_W = $clog2(NUM_UF);
  localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(sem_valor);
  localparam logic [TAG_W-1:0]  IDLE_TAG  = TAG_W'(FREE_REGISTER);

  if (NUM_UF < 2 || NUM_UF > 8) begin : g_bad_num_uf
    $error("cdb_scheduler: NUM_UF must be in 2..8");
  end
  if (TAG_BASE < 1 || TAG_BASE + NUM_UF - 1 >= (1 << TAG_W)) begin : g_bad_tag
    $error("cdb_scheduler: tags TAG_BASE..TAG_BASE+NUM_UF-1 must be nonzero and fit TAG_W");
  end

  logic [NUM_UF-1:0]             r_held;
  logic [NUM_UF-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]              r_ptr;
  logic                          r_we;
  logic [TAG_W-1:0]              r_tag;
  logic [DATA_W-1:0]             r_cdb_data;
  logic [NUM_UF-1:0]             r_gnt;
  logic [3:0]                    r_pend;

  logic [PTR_W-1:0]  w_win;
  logic              w_win_valid;
  logic [NUM_UF-1:0] w_win_oh;
  logic [NUM_UF-1:0] w_take;
  logic [NUM_UF-1:0] w_held_nxt;
  logic [3:0]        w_pend_nxt;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [TAG_W-1:0]  w_tag;

  rr_picker #(
    .NUM_UF (NUM_UF),
    .PTR_W  (PTR_W)
  ) u_picker (
    .i_req       (r_held),
    .i_ptr       (r_ptr),
    .o_win       (w_win),
    .o_win_valid (w_win_valid)
  );

  always_comb begin
    w_win_oh = '0;
    if (w_win_valid) w_win_oh = NUM_UF'(1) << w_win;
  end

  // A slot being granted this cycle can take a new result on the same edge,
  // letting one unit stream results back-to-back.
  assign Accept     = Flush ? '0 : (~r_held | w_win_oh);
  assign w_take     = Done & Accept;
  assign w_held_nxt = (r_held & ~w_win_oh) | w_take;
  assign w_ptr_nxt  = (w_win == PTR_W'(NUM_UF - 1)) ? '0 : w_win + 1'b1;
  assign w_tag      = TAG_W'(TAG_BASE) + TAG_W'(w_win);

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NUM_UF; i++)
      w_pend_nxt = w_pend_nxt + {3'b000, w_held_nxt[i]};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_held     <= '0;
      r_data     <= '0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_tag      <= IDLE_TAG;
      r_cdb_data <= IDLE_DATA;
      r_gnt      <= '0;
      r_pend     <= '0;
    end else if (Flush) begin
      // Held results are discarded; data storage is don't-care once empty.
      r_held     <= '0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_tag      <= IDLE_TAG;
      r_cdb_data <= IDLE_DATA;
      r_gnt      <= '0;
      r_pend     <= '0;
    end else begin
      r_held <= w_held_nxt;
      r_pend <= w_pend_nxt;
      for (int i = 0; i < NUM_UF; i++)
        if (w_take[i]) r_data[i] <= Q_bus[i*DATA_W +: DATA_W];
      if (w_win_valid) begin
        r_we       <= 1'b1;
        r_tag      <= w_tag;
        r_cdb_data <= r_data[w_win];
        r_gnt      <= w_win_oh;
        r_ptr      <= w_ptr_nxt;
      end else begin
        r_we       <= 1'b0;
        r_tag      <= IDLE_TAG;
        r_cdb_data <= IDLE_DATA;
        r_gnt      <= '0;
      end
    end
  end

  assign Write_Enable_CDB = r_we;
  assign Qi_CDB           = r_tag;
  assign Qi_CDB_data      = r_cdb_data;
  assign Grant_onehot     = r_gnt;
  assign Pending          = r_pend;

endmodule

// File: tb/tb_cdb_scheduler.sv
module tb_cdb_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 4;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            Flush = 1'b0;
  logic [N-1:0]    Done  = '0;
  logic [N*DW-1:0] Q_bus = '0;
  logic [N-1:0]    Accept;
  logic            Write_Enable_CDB;
  logic [TW-1:0]   Qi_CDB;
  logic [DW-1:0]   Qi_CDB_data;
  logic [N-1:0]    Grant_onehot;
  logic [3:0]      Pending;

  cdb_scheduler #(.NUM_UF(N), .DATA_W(DW), .TAG_W(TW), .TAG_BASE(1)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .Done(Done), .Q_bus(Q_bus),
    .Accept(Accept), .Write_Enable_CDB(Write_Enable_CDB), .Qi_CDB(Qi_CDB),
    .Qi_CDB_data(Qi_CDB_data), .Grant_onehot(Grant_onehot), .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots as a plain array; each edge: grant the first occupied slot scanning
  // from the pointer, then store any accepted new results.
  bit          m_held[N];
  logic [15:0] m_data[N];
  int          m_ptr;
  logic        m_we;
  logic [3:0]  m_tag;
  logic [15:0] m_cd;
  logic [3:0]  m_gnt;
  int          m_pend;

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (m_held[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] m_accept();
    logic [3:0] a;
    int w;
    w = m_winner();
    for (int i = 0; i < N; i++) a[i] = !Flush && (!m_held[i] || i == w);
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_held[i] = 0;
    m_ptr = 0; m_we = 0; m_tag = 0; m_cd = 16'hFFF0; m_gnt = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int w;
    logic [3:0] acc;
    acc = m_accept();
    w = m_winner();
    if (w >= 0) begin
      m_we = 1; m_tag = 4'(1 + w); m_cd = m_data[w]; m_gnt = 4'(1 << w);
      m_held[w] = 0; m_ptr = (w + 1) % N;
    end else begin
      m_we = 0; m_tag = 0; m_cd = 16'hFFF0; m_gnt = 0;
    end
    for (int i = 0; i < N; i++)
      if (Done[i] && acc[i]) begin
        m_held[i] = 1; m_data[i] = Q_bus[i*DW +: DW];
      end
    m_pend = 0;
    for (int i = 0; i < N; i++) m_pend += int'(m_held[i]);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge Clock or negedge Reset);
      if (!Reset || Flush) model_clear();
      else model_step();
    end
  end

  // ---------------- broadcast log + per-cycle compare ----------------
  typedef struct { logic [3:0] tag; logic [15:0] data; int c; } bc_t;
  bc_t log_q[$];

  initial begin
    forever begin
      @(negedge Clock);
      chk("we",      32'(Write_Enable_CDB), 32'(m_we));
      chk("tag",     32'(Qi_CDB),           32'(m_tag));
      chk("data",    32'(Qi_CDB_data),      32'(m_cd));
      chk("grant",   32'(Grant_onehot),     32'(m_gnt));
      chk("pending", 32'(Pending),          32'(m_pend));
      chk("accept",  32'(Accept),           32'(m_accept()));
      if (Write_Enable_CDB) log_q.push_back('{Qi_CDB, Qi_CDB_data, cyc});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic setq(input int u, input logic [15:0] v);
    Q_bus[u*DW +: DW] = v;
  endtask

  // Present a value on unit 0 and hold it until accepted; returns refused cycles.
  task automatic send0(input logic [15:0] v, output int waits);
    logic a;
    Done[0] = 1'b1; setq(0, v); waits = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge Clock); a = Accept[0];
      @(posedge Clock); #1;
      if (a) return;
      waits++;
    end
    chk("send0_timeout", 32'(waits), 32'(0));
  endtask

  task automatic chk_log(input string nm, input int n, input logic [3:0] tags[8],
                         input logic [15:0] vals[8]);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk({nm, "_tag"},  32'(log_q[i].tag),  32'(tags[i]));
      chk({nm, "_data"}, 32'(log_q[i].data), 32'(vals[i]));
      if (i > 0) chk({nm, "_gap"}, 32'(log_q[i].c - log_q[i-1].c), 32'(1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w;
    logic [3:0]  tg[8];
    logic [15:0] vl[8];

    tick(3);
    Reset = 1'b1;
    #1;
    chk("rst_we",   32'(Write_Enable_CDB), 32'(0));
    chk("rst_tag",  32'(Qi_CDB),           32'(0));
    chk("rst_data", 32'(Qi_CDB_data),      32'h0000FFF0);
    chk("rst_acc",  32'(Accept),           32'hF);
    chk("rst_pend", 32'(Pending),          32'(0));
    tick(1);

    // all four units at once, pointer 0
    log_q.delete();
    Done = 4'b1111; setq(0, 16'd10); setq(1, 16'd20); setq(2, 16'd30); setq(3, 16'd40);
    tick(1); Done = '0; tick(6);
    tg = '{1, 2, 3, 4, 0, 0, 0, 0}; vl = '{10, 20, 30, 40, 0, 0, 0, 0};
    chk_log("all_p0", 4, tg, vl);

    // single result from unit 1, two-cycle latency
    log_q.delete();
    t0 = cyc;
    Done = 4'b0010; setq(1, 16'h0042);
    tick(1); Done = '0; tick(4);
    tg = '{2, 0, 0, 0, 0, 0, 0, 0}; vl = '{16'h42, 0, 0, 0, 0, 0, 0, 0};
    chk_log("single", 1, tg, vl);
    if (log_q.size() > 0) chk("single_lat", 32'(log_q[0].c - t0), 32'(2));

    // all four again, pointer now 2
    log_q.delete();
    Done = 4'b1111; setq(0, 16'd10); setq(1, 16'd20); setq(2, 16'd30); setq(3, 16'd40);
    tick(1); Done = '0; tick(6);
    tg = '{3, 4, 1, 2, 0, 0, 0, 0}; vl = '{30, 40, 10, 20, 0, 0, 0, 0};
    chk_log("all_p2", 4, tg, vl);

    // back-pressure on unit 0 (pointer 2)
    log_q.delete();
    Done = 4'b1101; setq(0, 16'h33); setq(2, 16'h44); setq(3, 16'h55);
    tick(1);
    Done = 4'b0000;
    send0(16'd5, w);
    chk("bp_wait5", 32'(w), 32'(2));
    send0(16'd6, w);
    chk("bp_wait6", 32'(w), 32'(0));
    Done = '0; tick(5);
    tg = '{3, 4, 1, 1, 1, 0, 0, 0}; vl = '{16'h44, 16'h55, 16'h33, 5, 6, 0, 0, 0};
    chk_log("bp", 5, tg, vl);

    // flush with three slots held
    Done = 4'b0111; setq(0, 16'hA1); setq(1, 16'hA2); setq(2, 16'hA3);
    tick(1);
    chk("fl_pend3", 32'(Pending), 32'(3));
    log_q.delete();
    Done = '0; Flush = 1'b1;
    #1 chk("fl_acc", 32'(Accept), 32'(0));
    tick(1); Flush = 1'b0;
    chk("fl_pend0", 32'(Pending), 32'(0));
    chk("fl_we",    32'(Write_Enable_CDB), 32'(0));
    tick(4);
    chk("fl_none", 32'(log_q.size()), 32'(0));

    // reset during an active broadcast
    Done = 4'b0110; setq(1, 16'h77); setq(2, 16'h88);
    tick(1); Done = '0; tick(2);
    chk("mr_tag3", 32'(Qi_CDB), 32'(3));
    #1 Reset = 1'b0;
    #1;
    chk("mr_we",   32'(Write_Enable_CDB), 32'(0));
    chk("mr_tag",  32'(Qi_CDB),           32'(0));
    chk("mr_data", 32'(Qi_CDB_data),      32'h0000FFF0);
    chk("mr_gnt",  32'(Grant_onehot),     32'(0));
    chk("mr_pend", 32'(Pending),          32'(0));
    tick(1); Reset = 1'b1;
    log_q.delete();
    Done = 4'b0001; setq(0, 16'd7);
    tick(1); Done = '0; tick(4);
    tg = '{1, 0, 0, 0, 0, 0, 0, 0}; vl = '{7, 0, 0, 0, 0, 0, 0, 0};
    chk_log("post_rst", 1, tg, vl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
